// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
// Contents:
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : register-file geometry
//   ZERO_REG                           : index of the hardwired-zero register
//   wb_entry_t                         : one queued write {regIdx, data}
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 16;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] regIdx;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_fifo.sv
// Generic in-order circular FIFO (DEPTH entries of WIDTH bits), shared by the
// writeback queue and the load-return path.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   push, pushData  : enqueue pushData at the tail (caller guarantees room)
//   pop             : drop the head entry (caller guarantees non-empty)
//   headData        : current head entry
//   count/full/empty: occupancy
//   slotValid       : per-slot occupancy flag, indexed by physical slot
//   slotData        : all slots flattened, slot i at [i*WIDTH +: WIDTH]
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           headData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           slotValid,
  output logic [DEPTH*WIDTH-1:0]     slotData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] offset;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  // A slot is occupied when its distance from the head is below count.
  always_comb begin
    offset    = '0;
    slotValid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PTR_W'(i) - rdPtr;
      slotValid[i] = (CNT_W'(offset) < count);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gSlot
    assign slotData[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writer-side front end of the 16x16 register file. Buffers pipeline write
// requests in order and retires at most one per cycle onto the register-file
// write port, publishing which registers still have writes queued.
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   wr_valid/wr_ready           : request handshake
//   wr_reg, wr_data             : request payload
//   hold                        : suppress retirement this cycle
//   WriteReg, DstReg, DstData   : register-file write port
//   pend_mask                   : bit r set while a queued entry targets r
//   count, empty                : queue occupancy
import regfile_pkg::*;

module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_reg,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       hold,
  output logic                       WriteReg,
  output logic [ADDR_W-1:0]          DstReg,
  output logic [DATA_W-1:0]          DstData,
  output logic [NUM_REGS-1:0]        pend_mask,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     fifoEmpty;
  logic [ENTRY_W-1:0]       headEntry;
  logic [DEPTH-1:0]         slotValid;
  logic [DEPTH*ENTRY_W-1:0] slotData;

  // Handshake: a request transfers at a rising edge where wr_valid and
  // wr_ready are both 1. wr_ready is a function of queue state and hold only
  // (never of wr_valid); the requester holds wr_reg/wr_data stable while
  // wr_valid=1 and wr_ready=0. A full queue still accepts when the head
  // retires in the same cycle. Writes to the zero register complete the
  // handshake but are discarded.
  assign pop      = ~fifoEmpty & ~hold;
  assign wr_ready = ~full | pop;
  assign push     = wr_valid & wr_ready & (wr_reg != ADDR_W'(ZERO_REG));

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) uFifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pushData  ({wr_reg, wr_data}),
    .pop       (pop),
    .headData  (headEntry),
    .count     (count),
    .full      (full),
    .empty     (fifoEmpty),
    .slotValid (slotValid),
    .slotData  (slotData)
  );

  // The register file always accepts, so retiring is the same as popping.
  assign WriteReg = pop;
  assign DstReg   = fifoEmpty ? '0 : headEntry[ENTRY_W-1 -: ADDR_W];
  assign DstData  = fifoEmpty ? '0 : headEntry[DATA_W-1:0];
  assign empty    = fifoEmpty;

  // Includes the retiring head: the register-file bypass covers that entry,
  // but decode still sees it as pending until it has left the queue.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slotValid[i]) pend_mask[slotData[i*ENTRY_W + DATA_W +: ADDR_W]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic        hold;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] pend_mask;
  logic [2:0]  count;
  logic        empty;

  int compared;
  int mismatched;

  // Expected retirements {reg, data}, oldest first.
  logic [19:0] exp_q[$];

  regfile_writeback_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (4),
    .DATA_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .hold      (hold),
    .WriteReg  (WriteReg),
    .DstReg    (DstReg),
    .DstData   (DstData),
    .pend_mask (pend_mask),
    .count     (count),
    .empty     (empty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and holds it until the handshake completes.
  // Returns 1 time unit after the accepting edge with wr_valid dropped.
  task automatic push_one(input logic [3:0] r, input logic [15:0] d);
    int budget;
    wr_valid = 1'b1;
    wr_reg   = r;
    wr_data  = d;
    #1;
    budget = 0;
    while (!wr_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!wr_ready) begin
      check("push_timeout", 32'(wr_ready), 32'd1);
    end else if (r != 4'd0) begin
      exp_q.push_back({r, d});
    end
    tick();
    wr_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
      if (WriteReg) begin
        check("pop_when_empty", 32'(empty), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {12'd0, DstReg, DstData}, 32'hFFFF_FFFF);
        end else begin
          check("retire", {12'd0, DstReg, DstData}, {12'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    compared   = 0;
    mismatched = 0;
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_reg   = '0;
    wr_data  = '0;
    hold     = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst_writereg", 32'(WriteReg), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pend", 32'(pend_mask), 32'h0000);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_dst", {12'd0, DstReg, DstData}, 32'd0);

    // Single write: never written in its acceptance cycle, retires next cycle.
    wr_valid = 1'b1;
    wr_reg   = 4'd3;
    wr_data  = 16'hBEEF;
    #1;
    check("no_comb_write", 32'(WriteReg), 32'd0);
    exp_q.push_back({4'd3, 16'hBEEF});
    tick();
    wr_valid = 1'b0;
    #1;
    check("single_we", 32'(WriteReg), 32'd1);
    check("single_dst", {12'd0, DstReg, DstData}, {12'd0, 4'd3, 16'hBEEF});
    check("single_pend", 32'(pend_mask), 32'h0008);
    tick();
    #1;
    check("single_empty", 32'(empty), 32'd1);
    check("single_pend_clr", 32'(pend_mask), 32'h0000);

    // Fill under hold, then drain in order.
    hold = 1'b1;
    push_one(4'd1, 16'h0011);
    push_one(4'd2, 16'h0022);
    push_one(4'd3, 16'h0033);
    push_one(4'd4, 16'h0044);
    #1;
    check("fill_count", 32'(count), 32'd4);
    check("fill_ready", 32'(wr_ready), 32'd0);
    check("fill_pend", 32'(pend_mask), 32'h001E);
    check("fill_we", 32'(WriteReg), 32'd0);
    hold = 1'b0;
    #1;
    check("drain_ready", 32'(wr_ready), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("drain_we", 32'(WriteReg), 32'd1);
      check("drain_reg", 32'(DstReg), 32'(k));
      tick();
      #1;
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Full queue with simultaneous push and pop.
    hold = 1'b1;
    push_one(4'd1, 16'h0101);
    push_one(4'd2, 16'h0202);
    push_one(4'd3, 16'h0303);
    push_one(4'd4, 16'h0404);
    hold = 1'b0;
    push_one(4'd5, 16'h5555);
    #1;
    check("fullpp_count", 32'(count), 32'd4);
    repeat (3) tick();
    #1;
    check("fullpp_r5", {12'd0, DstReg, DstData}, {12'd0, 4'd5, 16'h5555});
    tick();
    #1;
    check("fullpp_empty", 32'(empty), 32'd1);

    // R0 drop and same-register ordering.
    hold = 1'b1;
    push_one(4'd7, 16'h0001);
    push_one(4'd0, 16'hFFFF);
    push_one(4'd7, 16'h0002);
    #1;
    check("r0_count", 32'(count), 32'd2);
    check("r7_pend", 32'(pend_mask), 32'h0080);
    hold = 1'b0;
    #1;
    check("r7_first", 32'(DstData), 32'h0001);
    check("r7_pend_1", 32'(pend_mask), 32'h0080);
    tick();
    #1;
    check("r7_second", 32'(DstData), 32'h0002);
    check("r7_pend_2", 32'(pend_mask), 32'h0080);
    tick();
    #1;
    check("r7_pend_clr", 32'(pend_mask), 32'h0000);
    check("r7_empty", 32'(empty), 32'd1);

    // Reset in the middle of operation discards queued entries.
    hold = 1'b1;
    push_one(4'd8, 16'h0808);
    push_one(4'd9, 16'h0909);
    push_one(4'd10, 16'h0A0A);
    #1;
    check("mid_count", 32'(count), 32'd3);
    rst = 1'b0;
    exp_q.delete();
    tick();
    rst  = 1'b1;
    hold = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_we", 32'(WriteReg), 32'd0);
    check("mid_rst_pend", 32'(pend_mask), 32'h0000);
    check("mid_rst_ready", 32'(wr_ready), 32'd1);
    repeat (6) tick();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
Writer-side front end for the 16x16 register file: it produces DstReg/DstData/WriteReg.
- Accepts write requests from the pipeline over a valid/ready handshake and buffers them in an in-order FIFO.
- Retires at most one write per cycle into the register file.
- Publishes a per-register pending mask. Decode uses it to stall reads of registers with queued writes; the register file's same-cycle bypass only covers the entry currently retiring.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 4, register index width (16 registers)
DATA_W, 16, register data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (asserted when 0)
wr_valid  in  1  write request valid
wr_ready  out  1  queue can accept this cycle
wr_reg  in  ADDR_W  destination register of request
wr_data  in  DATA_W  data of request
hold  in  1  1 = do not retire this cycle (register-file port borrowed)
WriteReg  out  1  register-file write enable
DstReg  out  ADDR_W  register-file write index
DstData  out  DATA_W  register-file write data
pend_mask  out  16  bit r = 1 if any queued entry targets register r
count  out  $clog2(DEPTH+1)  number of queued entries
empty  out  1  count == 0

Behaviour:
- Storage: circular buffer of {reg, data}, with rd_ptr, wr_ptr and count registers. Pointers wrap modulo DEPTH.
- Reset (rst==0 at a rising edge): rd_ptr=0, wr_ptr=0, count=0. Entry contents are don't-care. The reset clears any in-flight state, including mid-drain and full.
- While count==0 (including after reset): WriteReg=0, DstReg=0, DstData=0, pend_mask=0, count=0, empty=1, wr_ready=1.
- Head output (combinational from the head entry):
  - WriteReg = (count!=0) & ~hold.
  - DstReg / DstData = head entry when count!=0, else 0.
- pop = WriteReg. The register file always accepts, so the head leaves at the edge that ends a cycle with WriteReg=1.
- wr_ready = (count<DEPTH) | pop. When full, a simultaneous pop frees the slot in the same cycle.
- push = wr_valid & wr_ready & (wr_reg!=0).
  - Register 0 is hardwired to zero, so a handshake with wr_reg==0 completes but enqueues nothing. count, pend_mask and outputs are unchanged.
- Latency: a request accepted at edge N is the earliest candidate for WriteReg in the cycle after edge N. It is never written combinationally in the acceptance cycle.
- Ordering: strict FIFO. Two writes to the same register retire in acceptance order; the last one wins in the register file.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. Simultaneous push and pop is legal when full and when count==1.
- pend_mask: OR over valid entries of one-hot(reg). Computed combinationally from the current queue state, so the bit for the retiring entry is still set in its retire cycle. Bit 0 is always 0.
- hold: freezes retirement only. Pushes continue until full, after which wr_ready=0.
- Protocol rules:
  - Caller must keep wr_reg/wr_data stable while wr_valid=1 and wr_ready=0.
  - wr_ready does not depend on wr_valid (no combinational loop).
- Overflow and underflow cannot occur by construction. The bench checks this with assertions: count<=DEPTH, and no pop when empty.

Decomposition:
- Shared package (regfile_pkg):
  - REG_ADDR_W=4, REG_DATA_W=16, NUM_REGS=16
  - wb_entry_t struct {reg, data}
  - ZERO_REG=0
- One natural sub-module: wb_fifo. A generic DEPTH x (ADDR_W+DATA_W) circular FIFO with push/pop/count/full/empty, reusable for the load-return path.
- pend_mask generation and R0 filtering stay in the top.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 -> WriteReg=0, empty=1, count=0, pend_mask=0x0000, wr_ready=1.
- Single write: push r3=0xBEEF at edge N, hold=0 -> cycle N+1: WriteReg=1, DstReg=3, DstData=0xBEEF, pend_mask=0x0008. Cycle N+2: empty=1, pend_mask=0.
- Fill under hold: hold=1, push r1..r4 = 0x0011,0x0022,0x0033,0x0044 -> count=4, wr_ready=0, pend_mask=0x001E, WriteReg=0.
  - Then release hold -> four consecutive retires in order r1..r4, with wr_ready=1 from the first retire cycle.
- Full with simultaneous push/pop: queue full, hold=0, wr_valid with r5=0x5555 -> accepted in the same cycle, count stays 4, r5 retires 4 cycles later.
- R0 drop and same-register ordering:
  - push r0=0xFFFF -> handshake completes, count unchanged.
  - push r7=0x0001 then r7=0x0002 -> retires 0x0001 then 0x0002 to r7; pend_mask bit7 clears only after the second.
- Reset mid-operation: count=3 with hold=1, assert rst=0 for one edge -> count=0, WriteReg=0, pend_mask=0. No queued entry is ever written after reset.
